// File: rtl/float2ieee_conv.sv
// float2ieee_conv: widens a reduced float {s, e[Ne-1:0], m[Nm-1:0]} to an
// IEEE-754 single. Normals, zeros, infinities and NaNs finish in one cycle.
// Subnormals are renormalised one bit per cycle in NORM.
// Optional macro FLOAT2IEEE_NAN_CANON_EN: every NaN leaves as the canonical
// quiet NaN with its sign kept. Without it the NaN payload is widened.
`timescale 1ns/1ps
module float2ieee_conv #(
  parameter int Ne = 8,
  parameter int Nm = 23
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Ne+Nm:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_data,
  output logic [1:0]     out_class,
  output logic           out_subn
);

  localparam int BR = (1 << (Ne - 1)) - 1;        // reduced-format bias
  localparam int SH = 23 - Nm;                    // mantissa alignment
  localparam logic [7:0] SUBN_EXP = 8'(128 - BR); // subnormal starting exponent
  localparam logic [7:0] REBIAS   = 8'(127 - BR);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_reg, state_next;
  logic        sign_reg;
  logic [7:0]  exp_reg;
  logic [23:0] mant_reg;   // {hidden, fraction[22:0]}
  logic [1:0]  class_reg;
  logic        subn_reg;

  // Field decode of the offered word
  logic          in_s;
  logic [Ne-1:0] in_e;
  logic [Nm-1:0] in_m;
  logic [22:0]   m_al;
  logic [22:0]   nan_mant;
  logic [7:0]    exp_norm;
  logic          e_max, e_zero, m_zero;

  assign in_s     = in_data[Ne+Nm];
  assign in_e     = in_data[Ne+Nm-1:Nm];
  assign in_m     = in_data[Nm-1:0];
  assign m_al     = 23'(in_m) << SH;
  assign exp_norm = 8'(in_e) + REBIAS;
  assign e_max    = (in_e == {Ne{1'b1}});
  assign e_zero   = (in_e == '0);
  assign m_zero   = (in_m == '0);

`ifdef FLOAT2IEEE_NAN_CANON_EN
  assign nan_mant = 23'h400000;
`else
  assign nan_mant = m_al;
`endif

  // One normalisation step: shift mantissa up, pull exponent down
  logic [23:0] mant_shift;
  logic [7:0]  exp_dec;
  assign mant_shift = {mant_reg[22:0], 1'b0};
  assign exp_dec    = exp_reg - 8'd1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: subnormals detour through NORM unless already at the floor
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) begin
        if (e_zero && !m_zero && (SUBN_EXP > 8'd1)) state_next = NORM;
        else                                        state_next = DONE;
      end
      NORM: if (mant_shift[23] || (exp_dec == 8'd1)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers: loaded on accept, shifted in NORM, frozen in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_reg  <= 1'b0;
      exp_reg   <= 8'd0;
      mant_reg  <= 24'd0;
      class_reg <= 2'd0;
      subn_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          sign_reg <= in_s;
          subn_reg <= 1'b0;
          if (e_max) begin
            exp_reg   <= 8'hFF;
            mant_reg  <= m_zero ? 24'd0 : {1'b0, nan_mant};
            class_reg <= m_zero ? 2'd2 : 2'd3;
          end else if (e_zero) begin
            exp_reg   <= m_zero ? 8'd0 : SUBN_EXP;
            mant_reg  <= {1'b0, m_al};
            class_reg <= m_zero ? 2'd1 : 2'd0;
            subn_reg  <= !m_zero;
          end else begin
            exp_reg   <= exp_norm;
            mant_reg  <= {1'b1, m_al};
            class_reg <= 2'd0;
          end
        end
        NORM: begin
          mant_reg <= mant_shift;
          exp_reg  <= exp_dec;
        end
        default: ;
      endcase
    end
  end

  // A subnormal that never reached a hidden 1 stays an IEEE subnormal (e=0)
  logic [7:0] out_exp;
  assign out_exp   = (subn_reg && !mant_reg[23]) ? 8'd0 : exp_reg;
  assign out_data  = {sign_reg, out_exp, mant_reg[22:0]};
  assign out_class = class_reg;
  assign out_subn  = subn_reg;
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_float2ieee_conv.sv
// Bench for float2ieee_conv: a half-precision-like instance (Ne=5, Nm=10)
// and a full single-precision instance (Ne=8, Nm=23), checked against
// vector tables, hand-written sequences and a value-level reference model.
`timescale 1ns/1ps
module tb_float2ieee_conv;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16, os16;
  logic [15:0] id16;
  logic [31:0] od16;
  logic [1:0]  oc16;
  logic        iv32, ir32, ov32, or32, os32;
  logic [31:0] id32, od32;
  logic [1:0]  oc32;

  float2ieee_conv #(.Ne(5), .Nm(10)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .in_data(id16), .out_valid(ov16), .out_ready(or16), .out_data(od16),
    .out_class(oc16), .out_subn(os16));

  float2ieee_conv #(.Ne(8), .Nm(23)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .in_data(id32), .out_valid(ov32), .out_ready(or32), .out_data(od32),
    .out_class(oc32), .out_subn(os32));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

`ifdef FLOAT2IEEE_NAN_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  // Reference: interpret the reduced word as a real value and re-encode it
  // as a single. Latency is one cycle plus the number of doublings needed
  // to bring the leading one up to the hidden position (or hit exponent 1).
  function automatic void model(input int ne, input int nm, input logic [31:0] x,
                                output logic [31:0] o, output logic [1:0] c,
                                output logic sb, output int lat);
    int br, emax, e, m, p, be;
    bit s;
    br   = (1 << (ne - 1)) - 1;
    emax = (1 << ne) - 1;
    s    = x[ne+nm];
    e    = int'(x >> nm) & emax;
    m    = int'(x) & ((1 << nm) - 1);
    sb = 1'b0; lat = 1; c = 2'd0;
    if (e == emax) begin
      if (m == 0) begin
        o = {s, 8'hFF, 23'd0}; c = 2'd2;
      end else begin
        o = {s, 8'hFF, CANON ? 23'h400000 : 23'(m << (23 - nm))}; c = 2'd3;
      end
    end else if (e == 0 && m == 0) begin
      o = {s, 31'd0}; c = 2'd1;
    end else if (e == 0) begin
      sb = 1'b1;
      p = 0;
      for (int i = 0; i < nm; i++) if ((m >> i) & 1) p = i;
      be = p + 1 - br - nm + 127;
      if (be >= 1) begin
        o = {s, 8'(be), 23'((m << (23 - p)) & 32'h7FFFFF)};
        lat = 1 + nm - p;
      end else begin
        o = {s, 8'd0, 23'(m << (150 - br - nm))};
        lat = 1 + (127 - br);
      end
    end else begin
      o = {s, 8'(e + 127 - br), 23'(m << (23 - nm))};
    end
  endfunction

  // Offer one word, measure accept-to-valid latency, then consume it.
  task automatic xfer(input bit w, input logic [31:0] d, output logic [31:0] o,
                      output logic [1:0] c, output logic sb, output int lat);
    @(negedge clk);
    if (w) begin iv32 = 1'b1; id32 = d; end
    else   begin iv16 = 1'b1; id16 = d[15:0]; end
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    lat = 1;
    while (!(w ? ov32 : ov16) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(w ? ov32 : ov16)) lat = -1;
    o  = w ? od32 : od16;
    c  = w ? oc32 : oc16;
    sb = w ? os32 : os16;
    @(negedge clk);
    if (w) or32 = 1'b1; else or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; or32 = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  cls;
    logic        sb;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] o, eo, d;
    logic [1:0]  c, ec;
    logic        sb, esb;
    int          lat, elat;
    bit          stale;

    tbl[0] = '{0, 32'h3C00, 32'h3F800000, 2'd0, 1'b0, 1};
    tbl[1] = '{0, 32'h0001, 32'h33800000, 2'd0, 1'b1, 11};
    tbl[2] = '{0, 32'h8000, 32'h80000000, 2'd1, 1'b0, 1};
    tbl[3] = '{0, 32'h7C00, 32'h7F800000, 2'd2, 1'b0, 1};
    tbl[4] = '{0, 32'h7C01, CANON ? 32'h7FC00000 : 32'h7F802000, 2'd3, 1'b0, 1};
    tbl[5] = '{0, 32'hFBFF, 32'hC77FE000, 2'd0, 1'b0, 1};
    tbl[6] = '{0, 32'h0200, 32'h38000000, 2'd0, 1'b1, 2};
    tbl[7] = '{0, 32'h83FF, 32'hB87FC000, 2'd0, 1'b1, 2};
    tbl[8] = '{1, 32'h00000001, 32'h00000001, 2'd0, 1'b1, 1};
    tbl[9] = '{1, 32'hC0490FDB, 32'hC0490FDB, 2'd0, 1'b0, 1};

    reset_n = 1'b0;
    iv16 = 0; or16 = 0; id16 = '0;
    iv32 = 0; or32 = 0; id32 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", od16, 32'd0);
    chk("rst_out_valid", 32'(ov16), 32'd0);
    chk("rst_class_subn", {29'd0, oc16, os16}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    chk("rst_in_ready32", 32'(ir32), 32'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].w, tbl[i].din, o, c, sb, lat);
      $display("vec %0d in=%h out=%h class=%0d subn=%0d lat=%0d", i, tbl[i].din, o, c, sb, lat);
      chk($sformatf("vec%0d_data", i), o, tbl[i].dout);
      chk($sformatf("vec%0d_class", i), 32'(c), 32'(tbl[i].cls));
      chk($sformatf("vec%0d_subn", i), 32'(sb), 32'(tbl[i].sb));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure: result held, second offer waits for the consumer
    @(negedge clk);
    iv16 = 1'b1; id16 = 16'h3C00;
    @(posedge clk); #1;
    id16 = 16'h4000;
    chk("bp_valid", 32'(ov16), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      $display("bp cycle %0d out=%h valid=%0d in_ready=%0d", k, od16, ov16, ir16);
      chk("bp_hold_data", od16, 32'h3F800000);
      chk("bp_in_ready", 32'(ir16), 32'd0);
    end
    @(negedge clk);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("bp_released_ready", 32'(ir16), 32'd1);
    chk("bp_released_valid", 32'(ov16), 32'd0);
    @(posedge clk); #1;
    iv16 = 1'b0;
    $display("bp second out=%h valid=%0d", od16, ov16);
    chk("bp_second_valid", 32'(ov16), 32'd1);
    chk("bp_second_data", od16, 32'h40000000);
    @(negedge clk);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;

    // Reset during the third NORM cycle of the smallest subnormal
    @(negedge clk);
    iv16 = 1'b1; id16 = 16'h0001;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    $display("reset mid-NORM out=%h valid=%0d", od16, ov16);
    chk("mid_rst_data", od16, 32'd0);
    chk("mid_rst_valid", 32'(ov16), 32'd0);
    chk("mid_rst_class_subn", {29'd0, oc16, os16}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 32'(ir16), 32'd1);
    stale = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ov16) stale = 1'b1;
    end
    chk("mid_rst_no_stale", 32'(stale), 32'd0);

    // Randomised reduced-format words, every fourth forced subnormal
    for (int i = 0; i < 150; i++) begin
      d = 32'($urandom_range(0, 16'hFFFF));
      if (i % 4 == 0) d[14:10] = 5'd0;
      model(5, 10, d, eo, ec, esb, elat);
      xfer(1'b0, d, o, c, sb, lat);
      $display("rnd16 in=%h out=%h exp=%h lat=%0d", d[15:0], o, eo, lat);
      chk("rnd16_data", o, eo);
      chk("rnd16_class", 32'(c), 32'(ec));
      chk("rnd16_subn", 32'(sb), 32'(esb));
      chk("rnd16_lat", 32'(lat), 32'(elat));
    end

    // Randomised singles: identity (except NaN canonicalisation when enabled)
    for (int i = 0; i < 150; i++) begin
      d = $urandom;
      if (i % 5 == 0) d[30:23] = 8'd0;
      model(8, 23, d, eo, ec, esb, elat);
      xfer(1'b1, d, o, c, sb, lat);
      $display("rnd32 in=%h out=%h exp=%h lat=%0d", d, o, eo, lat);
      chk("rnd32_data", o, eo);
      chk("rnd32_class", 32'(c), 32'(ec));
      chk("rnd32_subn", 32'(sb), 32'(esb));
      chk("rnd32_lat", 32'(lat), 32'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
